// File: rtl/testclk_drp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : testclk_drp_pkg
//  Description : Shared types and constants for the test-clock DRP
//                reconfiguration controller: FSM state encoding, DRP entry
//                layout, DRP bus widths and the two-profile register table.
//  Revision    : 1.0 - initial release
// ============================================================================
package testclk_drp_pkg;

    localparam int c_DRP_ADDR_W   = 7;
    localparam int c_DRP_DATA_W   = 16;
    localparam int c_TABLE_DEPTH  = 8;
    localparam int c_NUM_PROFILES = 2;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ASSERT_RST = 4'd1,
        S_READ       = 4'd2,
        S_WAIT_RD    = 4'd3,
        S_WRITE      = 4'd4,
        S_WAIT_WR    = 4'd5,
        S_RELEASE    = 4'd6,
        S_WAIT_LOCK  = 4'd7,
        S_DONE       = 4'd8,
        S_ERR        = 4'd9
    } drp_state_t;

    // One read-modify-write step: bits set in mask keep the value read back,
    // bits clear in mask take the value from data.
    typedef struct packed {
        logic [c_DRP_ADDR_W-1:0] addr;
        logic [c_DRP_DATA_W-1:0] mask;
        logic [c_DRP_DATA_W-1:0] data;
    } drp_entry_t;

    localparam drp_entry_t c_PROFILE_TABLE [c_NUM_PROFILES][c_TABLE_DEPTH] = '{
        '{ {7'h08, 16'hF000, 16'h0145},
           {7'h09, 16'hFC00, 16'h0000},
           {7'h0A, 16'hF000, 16'h0083},
           {7'h0B, 16'hFC00, 16'h0080},
           {7'h14, 16'hF000, 16'h1041},
           {7'h15, 16'hFC00, 16'h0000},
           {7'h18, 16'hFC00, 16'h01F4},
           {7'h28, 16'h0000, 16'hFFFF} },
        '{ {7'h08, 16'hF000, 16'h0187},
           {7'h09, 16'hFC00, 16'h0080},
           {7'h0C, 16'hF000, 16'h0104},
           {7'h0D, 16'hFC00, 16'h0000},
           {7'h14, 16'hF000, 16'h1145},
           {7'h15, 16'hFC00, 16'h0080},
           {7'h4E, 16'h66FF, 16'h9000},
           {7'h4F, 16'h666F, 16'h0100} }
    };

    function automatic logic [c_DRP_DATA_W-1:0] merge_data(
        input logic [c_DRP_DATA_W-1:0] rd_data,
        input drp_entry_t              entry
    );
        return (rd_data & entry.mask) | (entry.data & ~entry.mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/testclk_drp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : testclk_drp_ctrl
//  Description : Reconfigures a clocking network through its DRP port.
//                On request, holds the network in reset, performs one
//                read-modify-write per table entry of the selected profile,
//                releases reset and waits for lock. Reports completion or a
//                DRDY/LOCKED timeout with a one-cycle pulse.
//  Ports       : CLK_IN1        - clock (also the DRP clock)
//                RESET_N        - synchronous active-low reset
//                RECONFIG_REQ   - start request (accepted in IDLE only)
//                PROFILE_SEL    - profile select, latched on accept
//                RECONFIG_BUSY  - high whenever not IDLE
//                RECONFIG_DONE  - success pulse
//                RECONFIG_ERR   - timeout pulse
//                DADDR/DI/DO/DEN/DWE/DRDY - DRP bus
//                MMCM_RST       - reset to the clocking network
//                LOCKED         - lock indication from the clocking network
//  Revision    : 1.0 - initial release
// ============================================================================
module testclk_drp_ctrl
    import testclk_drp_pkg::*;
#(
    parameter int TCQ          = 100,
    parameter int NUM_ENTRIES  = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                    CLK_IN1,
    input  logic                    RESET_N,
    input  logic                    RECONFIG_REQ,
    input  logic                    PROFILE_SEL,
    output logic                    RECONFIG_BUSY,
    output logic                    RECONFIG_DONE,
    output logic                    RECONFIG_ERR,
    output logic [c_DRP_ADDR_W-1:0] DADDR,
    output logic [c_DRP_DATA_W-1:0] DI,
    input  logic [c_DRP_DATA_W-1:0] DO,
    output logic                    DEN,
    output logic                    DWE,
    input  logic                    DRDY,
    output logic                    MMCM_RST,
    input  logic                    LOCKED
);

    // The shared wait counter only ever needs to reach TIMEOUT-1 of the
    // larger timeout; never narrower than 16 bits.
    localparam int c_MAX_TIMEOUT = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int c_CNT_RAW_W   = (c_MAX_TIMEOUT > 1) ? $clog2(c_MAX_TIMEOUT) : 1;
    localparam int c_CNT_W       = (c_CNT_RAW_W < 16) ? 16 : c_CNT_RAW_W;
    localparam int c_IDX_W       = $clog2(c_TABLE_DEPTH);

    // TCQ is kept for interface compatibility with behavioural models; the
    // synthesizable registers carry no delay. NUM_ENTRIES must not exceed
    // the table depth. These blocks elaborate to nothing.
    if (TCQ < 0) begin : g_tcq_unused
    end
    if (NUM_ENTRIES > c_TABLE_DEPTH) begin : g_num_entries_too_large
    end

    drp_state_t                r_state;
    drp_state_t                w_state_nxt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_IDX_W-1:0]        w_idx_nxt;
    logic                      r_profile;
    logic                      w_profile_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      w_cnt_tick;
    logic [c_DRP_ADDR_W-1:0]   r_daddr;
    logic [c_DRP_DATA_W-1:0]   r_di;
    drp_entry_t                w_entry;
    logic                      w_last_entry;
    logic                      w_drdy_expired;
    logic                      w_lock_expired;

    // Entry for the index/profile that will be current next cycle, so that
    // DADDR/DI are already valid on the cycle DEN is raised.
    assign w_entry        = c_PROFILE_TABLE[w_profile_nxt][w_idx_nxt];
    assign w_last_entry   = (r_idx == c_IDX_W'(NUM_ENTRIES - 1));
    assign w_drdy_expired = (r_cnt == c_CNT_W'(DRDY_TIMEOUT - 1));
    assign w_lock_expired = (r_cnt == c_CNT_W'(LOCK_TIMEOUT - 1));

    assign DADDR = r_daddr;
    assign DI    = r_di;

    always_ff @(posedge CLK_IN1) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_profile <= 1'b0;
            r_cnt     <= '0;
            r_daddr   <= '0;
            r_di      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_profile <= w_profile_nxt;
            // Counter runs only while remaining in a wait state, so it is
            // zero on the first cycle of every wait state.
            if (w_cnt_tick) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if ((w_state_nxt == S_READ) || (w_state_nxt == S_WRITE)) begin
                r_daddr <= w_entry.addr;
            end
            // WRITE is only entered from WAIT_RD with DRDY high, so DO holds
            // the read-back value on this edge.
            if (w_state_nxt == S_WRITE) begin
                r_di <= merge_data(DO, w_entry);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_profile_nxt = r_profile;
        w_cnt_tick    = 1'b0;
        RECONFIG_BUSY = 1'b1;
        RECONFIG_DONE = 1'b0;
        RECONFIG_ERR  = 1'b0;
        DEN           = 1'b0;
        DWE           = 1'b0;
        MMCM_RST      = 1'b0;

        case (r_state)
            S_IDLE: begin
                RECONFIG_BUSY = 1'b0;
                if (RECONFIG_REQ) begin
                    w_state_nxt   = S_ASSERT_RST;
                    w_idx_nxt     = '0;
                    w_profile_nxt = PROFILE_SEL;
                end
            end
            S_ASSERT_RST: begin
                MMCM_RST    = 1'b1;
                w_state_nxt = S_READ;
            end
            S_READ: begin
                MMCM_RST    = 1'b1;
                DEN         = 1'b1;
                w_state_nxt = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                MMCM_RST = 1'b1;
                if (DRDY) begin
                    w_state_nxt = S_WRITE;
                end else if (w_drdy_expired) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_tick = 1'b1;
                end
            end
            S_WRITE: begin
                MMCM_RST    = 1'b1;
                DEN         = 1'b1;
                DWE         = 1'b1;
                w_state_nxt = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                MMCM_RST = 1'b1;
                if (DRDY) begin
                    if (w_last_entry) begin
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_state_nxt = S_READ;
                        w_idx_nxt   = r_idx + c_IDX_W'(1);
                    end
                end else if (w_drdy_expired) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_tick = 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (LOCKED) begin
                    w_state_nxt = S_DONE;
                end else if (w_lock_expired) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_tick = 1'b1;
                end
            end
            S_DONE: begin
                RECONFIG_DONE = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            S_ERR: begin
                RECONFIG_ERR = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                RECONFIG_BUSY = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_testclk_drp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_testclk_drp_ctrl
//  Description : Scoreboard bench for testclk_drp_ctrl. Stimulus pushes the
//                expected DRP accesses and completion events; a monitor pops
//                and compares each time the DUT raises DEN, DONE or ERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_testclk_drp_ctrl;

    localparam int c_NUM = 8;
    localparam int c_DT  = 64;
    localparam int c_LT  = 200;

    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;
    localparam int R_NONE = 0, R_DEN = 1, R_FALL = 2;

    // Independent copy of the register profiles.
    localparam logic [6:0] T_ADDR [0:1][0:7] = '{
        '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15, 7'h18, 7'h28},
        '{7'h08, 7'h09, 7'h0C, 7'h0D, 7'h14, 7'h15, 7'h4E, 7'h4F}};
    localparam logic [15:0] T_MASK [0:1][0:7] = '{
        '{16'hF000, 16'hFC00, 16'hF000, 16'hFC00, 16'hF000, 16'hFC00, 16'hFC00, 16'h0000},
        '{16'hF000, 16'hFC00, 16'hF000, 16'hFC00, 16'hF000, 16'hFC00, 16'h66FF, 16'h666F}};
    localparam logic [15:0] T_DATA [0:1][0:7] = '{
        '{16'h0145, 16'h0000, 16'h0083, 16'h0080, 16'h1041, 16'h0000, 16'h01F4, 16'hFFFF},
        '{16'h0187, 16'h0080, 16'h0104, 16'h0000, 16'h1145, 16'h0080, 16'h9000, 16'h0100}};

    typedef struct {
        int          kind;
        logic [6:0]  addr;
        logic [15:0] di;
        int          ref_sel;
        int          delay;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        RECONFIG_REQ = 1'b0;
    logic        PROFILE_SEL = 1'b0;
    logic        RECONFIG_BUSY, RECONFIG_DONE, RECONFIG_ERR;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] tb_do = 16'h0000;
    logic        DEN, DWE;
    logic        DRDY = 1'b0;
    logic        MMCM_RST;
    logic        LOCKED = 1'b0;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_den = 0;
    int   last_fall = 0;
    int   mon_wr_cnt = 0;
    bit   mon_en = 1'b0;
    bit   chk_idle = 1'b0;
    logic prev_mmcm = 1'b0;
    int   resp_cnt = 0;
    int   resp_rd_cnt = 0;
    int   resp_hold = 0;

    always #5 clk = ~clk;

    testclk_drp_ctrl #(
        .TCQ          (100),
        .NUM_ENTRIES  (c_NUM),
        .DRDY_TIMEOUT (c_DT),
        .LOCK_TIMEOUT (c_LT)
    ) dut (
        .CLK_IN1       (clk),
        .RESET_N       (RESET_N),
        .RECONFIG_REQ  (RECONFIG_REQ),
        .PROFILE_SEL   (PROFILE_SEL),
        .RECONFIG_BUSY (RECONFIG_BUSY),
        .RECONFIG_DONE (RECONFIG_DONE),
        .RECONFIG_ERR  (RECONFIG_ERR),
        .DADDR         (DADDR),
        .DI            (DI),
        .DO            (tb_do),
        .DEN           (DEN),
        .DWE           (DWE),
        .DRDY          (DRDY),
        .MMCM_RST      (MMCM_RST),
        .LOCKED        (LOCKED)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rd(input int p, input int i);
        exp_t e;
        e.kind = K_RD; e.addr = T_ADDR[p][i]; e.di = '0; e.ref_sel = R_NONE; e.delay = 0;
        sb_q.push_back(e);
    endtask

    task automatic push_rw(input int p, input int i, input logic [15:0] dov);
        exp_t e;
        push_rd(p, i);
        e.kind = K_WR; e.addr = T_ADDR[p][i];
        e.di = (dov & T_MASK[p][i]) | (T_DATA[p][i] & ~T_MASK[p][i]);
        e.ref_sel = R_NONE; e.delay = 0;
        sb_q.push_back(e);
    endtask

    task automatic push_evt(input int kind, input int ref_sel, input int delay);
        exp_t e;
        e.kind = kind; e.addr = '0; e.di = '0; e.ref_sel = ref_sel; e.delay = delay;
        sb_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'b0, RECONFIG_BUSY}, 0);
        chk({tag, "_done"},  {31'b0, RECONFIG_DONE}, 0);
        chk({tag, "_err"},   {31'b0, RECONFIG_ERR},  0);
        chk({tag, "_den"},   {31'b0, DEN},           0);
        chk({tag, "_dwe"},   {31'b0, DWE},           0);
        chk({tag, "_mmcm"},  {31'b0, MMCM_RST},      0);
        chk({tag, "_daddr"}, {25'b0, DADDR},         0);
        chk({tag, "_di"},    {16'b0, DI},            0);
    endtask

    task automatic issue_req(input logic p);
        PROFILE_SEL  = p;
        RECONFIG_REQ = 1'b1;
        @(negedge clk);
        RECONFIG_REQ = 1'b0;
        chk("req_busy", {31'b0, RECONFIG_BUSY}, 1);
        chk("req_mmcm_rst", {31'b0, MMCM_RST}, 1);
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        while (MMCM_RST !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        while (MMCM_RST !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        chk("mmcm_release_seen", {31'b0, MMCM_RST}, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (RECONFIG_BUSY !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        chk("idle_seen", {31'b0, RECONFIG_BUSY}, 0);
    endtask

    task automatic run_seq(input logic p, input logic [15:0] dov, input bit lock_never, input bit poke);
        tb_do = dov;
        for (int i = 0; i < c_NUM; i++) push_rw(p, i, dov);
        if (lock_never) push_evt(K_ERR, R_FALL, c_LT + 1);
        else            push_evt(K_DONE, R_FALL, 11);
        issue_req(p);
        if (poke) begin
            repeat (4) @(negedge clk);
            PROFILE_SEL  = ~p;
            RECONFIG_REQ = 1'b1;
            @(negedge clk);
            RECONFIG_REQ = 1'b0;
            PROFILE_SEL  = p;
        end
        wait_fall(2000);
        if (!lock_never) begin
            repeat (10) @(negedge clk);
            LOCKED = 1'b1;
        end
        wait_idle(c_LT + 50);
        LOCKED = 1'b0;
    endtask

    // DRP responder: DRDY one cycle wide, three cycles after each DEN.
    initial begin : responder
        forever begin
            @(negedge clk);
            DRDY = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) DRDY = 1'b1;
            end
            if (DEN === 1'b1) begin
                if (DWE !== 1'b1) resp_rd_cnt++;
                if (!(DWE !== 1'b1 && resp_rd_cnt == resp_hold)) resp_cnt = 3;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (chk_idle) begin
                    chk_idle = 1'b0;
                    chk("post_evt_busy", {31'b0, RECONFIG_BUSY}, 0);
                    chk("post_evt_mmcm_rst", {31'b0, MMCM_RST}, 0);
                end
                if (prev_mmcm === 1'b1 && MMCM_RST === 1'b0) last_fall = cyc;
                prev_mmcm = MMCM_RST;
                if (DEN === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_den", {25'b0, DADDR}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("den_kind_dwe", {31'b0, DWE}, (e.kind == K_WR) ? 1 : 0);
                        chk("daddr", {25'b0, DADDR}, {25'b0, e.addr});
                        if (e.kind == K_WR) begin
                            chk("di", {16'b0, DI}, {16'b0, e.di});
                            mon_wr_cnt++;
                        end
                        chk("mmcm_rst_during_drp", {31'b0, MMCM_RST}, 1);
                        last_den = cyc;
                    end
                end
                if (RECONFIG_DONE === 1'b1 || RECONFIG_ERR === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_evt", {30'b0, RECONFIG_ERR, RECONFIG_DONE}, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("evt_done", {31'b0, RECONFIG_DONE}, (e.kind == K_DONE) ? 1 : 0);
                        chk("evt_err",  {31'b0, RECONFIG_ERR},  (e.kind == K_ERR) ? 1 : 0);
                        if (e.ref_sel == R_DEN)  chk("evt_delay_from_den",  cyc - last_den,  e.delay);
                        if (e.ref_sel == R_FALL) chk("evt_delay_from_fall", cyc - last_fall, e.delay);
                        chk_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int base;
        int n;
        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        RESET_N = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // Profile 0, read-back all ones: first write DI = 0xF145
        run_seq(1'b0, 16'hFFFF, 1'b0, 1'b0);

        // Profile 1 with a second request and toggled select while busy
        run_seq(1'b1, 16'h0000, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_req_not_queued", {31'b0, RECONFIG_BUSY}, 0);

        // DRDY withheld after the third READ
        tb_do = 16'hA5A5;
        resp_rd_cnt = 0;
        resp_hold = 3;
        push_rw(0, 0, 16'hA5A5);
        push_rw(0, 1, 16'hA5A5);
        push_rd(0, 2);
        push_evt(K_ERR, R_DEN, c_DT + 1);
        issue_req(1'b0);
        wait_idle(2000);
        resp_hold = 0;
        repeat (3) @(negedge clk);

        // LOCKED never rises
        run_seq(1'b1, 16'h1234, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset during WAIT_WR of entry 4; the pending DRDY lands in IDLE
        tb_do = 16'h5A5A;
        for (int i = 0; i < 5; i++) push_rw(0, i, 16'h5A5A);
        base = mon_wr_cnt;
        issue_req(1'b0);
        n = 0;
        while (mon_wr_cnt < base + 5 && n < 1000) begin @(negedge clk); n++; end
        chk("reset_test_writes_seen", mon_wr_cnt - base, 5);
        @(negedge clk);
        RESET_N = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        RESET_N = 1'b1;
        repeat (10) @(negedge clk);
        chk("after_reset_busy", {31'b0, RECONFIG_BUSY}, 0);
        chk("after_reset_sb_empty", sb_q.size(), 0);
        run_seq(1'b0, 16'h5A5A, 1'b0, 1'b0);

        // Request held high across completion
        tb_do = 16'h0F0F;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < c_NUM; i++) push_rw(1, i, 16'h0F0F);
            push_evt(K_DONE, R_FALL, 11);
        end
        PROFILE_SEL  = 1'b1;
        RECONFIG_REQ = 1'b1;
        wait_fall(2000);
        repeat (10) @(negedge clk);
        LOCKED = 1'b1;
        n = 0;
        while (RECONFIG_DONE !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("held_first_done", {31'b0, RECONFIG_DONE}, 1);
        LOCKED = 1'b0;
        @(negedge clk);
        chk("held_idle_cycle", {31'b0, RECONFIG_BUSY}, 0);
        @(negedge clk);
        chk("held_restart_busy", {31'b0, RECONFIG_BUSY}, 1);
        RECONFIG_REQ = 1'b0;
        wait_fall(2000);
        repeat (10) @(negedge clk);
        LOCKED = 1'b1;
        wait_idle(200);
        LOCKED = 1'b0;
        repeat (3) @(negedge clk);

        chk("final_sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
